data_mem_responder: RTL and testbench



---
 rtl/data_mem_if.sv | 29 ++
 rtl/data_mem_responder.sv | 155 +++++++++++++++
 tb/tb_data_mem_responder.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_if.sv
// Data-memory bus between the single-cycle controller (master) and the data-memory
// responder (slave).
//   MemRead, MemWrite : level requests, held by the controller while busy is high
//   addr, wdata       : word address (ALU result) and write data (RS2)
//   rdata, rvalid     : read data toward the MemtoReg mux, and its valid flag
//   busy              : stall request to the controller
//   err               : address out of range
interface data_mem_if #(
  parameter int unsigned NBITS = 8
);
  logic             MemRead;
  logic             MemWrite;
  logic [NBITS-1:0] addr;
  logic [NBITS-1:0] wdata;
  logic [NBITS-1:0] rdata;
  logic             rvalid;
  logic             busy;
  logic             err;

  modport master (
    output MemRead, MemWrite, addr, wdata,
    input  rdata, rvalid, busy, err
  );

  modport slave (
    input  MemRead, MemWrite, addr, wdata,
    output rdata, rvalid, busy, err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder serving word reads and writes from the single-cycle controller.
// DEPTH x NBITS register array indexed by the low address bits; addresses >= DEPTH
// drop writes, read as 0 and raise err.
//
// Optional feature macro: DMEM_WAIT_EN
//   defined   : IDLE/WAIT/DONE FSM holds busy for LATENCY cycles per access, commits the
//               latched write / captures the latched read when entering DONE, and presents
//               rvalid/err in DONE.
//   undefined : zero-wait responder; busy tied 0, write on the clock edge, combinational
//               read path.
//
// Ports:
//   clock : clock
//   reset : synchronous, active-high reset (clears state and all memory words)
//   bus   : data_mem_if slave modport (MemRead, MemWrite, addr, wdata, rdata, rvalid,
//           busy, err)
module data_mem_responder #(
  parameter int unsigned NBITS   = 8,
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned LATENCY = 2
) (
  input logic        clock,
  input logic        reset,
  data_mem_if.slave  bus
);

  localparam int unsigned    IdxW   = $clog2(DEPTH);
  localparam logic [NBITS:0] DepthW = (NBITS + 1)'(DEPTH);

  logic            req;
  logic [IdxW-1:0] idx;
  logic            oor;

  assign req = bus.MemRead | bus.MemWrite;
  assign idx = bus.addr[IdxW-1:0];
  assign oor = {1'b0, bus.addr} >= DepthW;

  logic [NBITS-1:0] mem [DEPTH];

`ifdef DMEM_WAIT_EN

  localparam int unsigned CntW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [IdxW-1:0]  idx_q;
  logic             oor_q;
  logic             wr_q;
  logic             rd_q;
  logic [NBITS-1:0] wdata_q;
  logic [NBITS-1:0] rdata_q;

  // The memory side effect happens on the edge that enters DONE. With LATENCY == 1 that
  // edge is the request edge itself, so the live inputs are used instead of the latches.
  logic             commit;
  logic [IdxW-1:0]  c_idx;
  logic             c_oor;
  logic             c_wr;
  logic             c_rd;
  logic [NBITS-1:0] c_wdata;

  always_comb begin
    commit  = 1'b0;
    c_idx   = idx_q;
    c_oor   = oor_q;
    c_wr    = wr_q;
    c_rd    = rd_q;
    c_wdata = wdata_q;
    if (state_q == StIdle && req && LATENCY == 1) begin
      commit  = 1'b1;
      c_idx   = idx;
      c_oor   = oor;
      c_wr    = bus.MemWrite;
      c_rd    = bus.MemRead & ~bus.MemWrite;
      c_wdata = bus.wdata;
    end else if (state_q == StWait && cnt_q == CntW'(1)) begin
      commit = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      oor_q   <= 1'b0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req) begin
            idx_q   <= idx;
            oor_q   <= oor;
            wr_q    <= bus.MemWrite;
            rd_q    <= bus.MemRead & ~bus.MemWrite;  // write wins over a read
            wdata_q <= bus.wdata;
            cnt_q   <= CntW'(LATENCY - 1);
            state_q <= (LATENCY > 1) ? StWait : StDone;
          end
        end
        StWait: begin
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_q <= StDone;
          end
        end
        // Controller still holds the finished request here, so inputs are ignored.
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase

      if (commit) begin
        if (c_wr && !c_oor) begin
          mem[c_idx] <= c_wdata;
        end
        if (c_rd) begin
          rdata_q <= c_oor ? '0 : mem[c_idx];
        end
      end
    end
  end

  assign bus.busy   = (state_q == StIdle && req) || (state_q == StWait);
  assign bus.rvalid = (state_q == StDone) && rd_q;
  assign bus.err    = (state_q == StDone) && oor_q;
  assign bus.rdata  = rdata_q;

`else

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (bus.MemWrite && !oor) begin
      mem[idx] <= bus.wdata;
    end
  end

  assign bus.busy   = 1'b0;
  assign bus.rdata  = (bus.MemRead && !oor) ? mem[idx] : '0;
  assign bus.rvalid = bus.MemRead & ~bus.MemWrite;
  assign bus.err    = req & oor;

`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (NBITS=8, DEPTH=32, LATENCY=2).
// Follows the DMEM_WAIT_EN macro of the build: the wait-state sequence when defined,
// the zero-wait sequence otherwise.
module tb_data_mem_responder;

  logic clock;
  logic reset;
  int   n_chk;
  int   n_bad;

  data_mem_if #(.NBITS(8)) bus ();

  data_mem_responder #(
    .NBITS  (8),
    .DEPTH  (32),
    .LATENCY(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here, outputs sampled #1 later.
  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic drive(input logic wr, input logic rd, input logic [7:0] a, input logic [7:0] d);
    bus.MemWrite = wr;
    bus.MemRead  = rd;
    bus.addr     = a;
    bus.wdata    = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    cyc();
    cyc();
    reset = 1'b0;
  endtask

`ifdef DMEM_WAIT_EN
  // One full access with the request held through DONE; returns the DONE-cycle outputs.
  task automatic do_acc(input string tag, input logic wr, input logic rd, input logic [7:0] a,
                        input logic [7:0] d, output logic [7:0] rdo, output logic rvo,
                        output logic ero);
    cyc();
    drive(wr, rd, a, d);
    #1 check_eq({tag, "_busy_req"}, 32'(bus.busy), 32'd1);
    cyc();
    #1 check_eq({tag, "_busy_wait"}, 32'(bus.busy), 32'd1);
    cyc();
    #1 check_eq({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
    rdo = bus.rdata;
    rvo = bus.rvalid;
    ero = bus.err;
  endtask
`endif

  initial begin
    logic [7:0] rd_v;
    logic       rv_v;
    logic       er_v;
    n_chk = 0;
    n_bad = 0;
    do_reset();
    #1;
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_rvalid", 32'(bus.rvalid), 32'd0);
    check_eq("rst_err", 32'(bus.err), 32'd0);
    check_eq("rst_rdata", 32'(bus.rdata), 32'd0);

`ifdef DMEM_WAIT_EN
    do_acc("w5", 1'b1, 1'b0, 8'd5, 8'hA5, rd_v, rv_v, er_v);
    check_eq("w5_rvalid", 32'(rv_v), 32'd0);
    check_eq("w5_err", 32'(er_v), 32'd0);
    do_acc("r5", 1'b0, 1'b1, 8'd5, 8'h00, rd_v, rv_v, er_v);
    check_eq("r5_rdata", 32'(rd_v), 32'hA5);
    check_eq("r5_rvalid", 32'(rv_v), 32'd1);
    check_eq("r5_err", 32'(er_v), 32'd0);

    do_acc("both3", 1'b1, 1'b1, 8'd3, 8'h3C, rd_v, rv_v, er_v);
    check_eq("both3_rvalid", 32'(rv_v), 32'd0);
    do_acc("r3", 1'b0, 1'b1, 8'd3, 8'h00, rd_v, rv_v, er_v);
    check_eq("r3_rdata", 32'(rd_v), 32'h3C);
    check_eq("r3_rvalid", 32'(rv_v), 32'd1);

    do_acc("w40", 1'b1, 1'b0, 8'd40, 8'hFF, rd_v, rv_v, er_v);
    check_eq("w40_err", 32'(er_v), 32'd1);
    check_eq("w40_rvalid", 32'(rv_v), 32'd0);
    do_acc("r40", 1'b0, 1'b1, 8'd40, 8'h00, rd_v, rv_v, er_v);
    check_eq("r40_rdata", 32'(rd_v), 32'h00);
    check_eq("r40_rvalid", 32'(rv_v), 32'd1);
    check_eq("r40_err", 32'(er_v), 32'd1);
    do_acc("r8", 1'b0, 1'b1, 8'd8, 8'h00, rd_v, rv_v, er_v);
    check_eq("r8_alias_rdata", 32'(rd_v), 32'h00);
    check_eq("r8_err", 32'(er_v), 32'd0);

    // Inputs changed during WAIT must not affect the latched write.
    cyc();
    drive(1'b1, 1'b0, 8'd10, 8'h42);
    cyc();
    drive(1'b1, 1'b0, 8'd11, 8'h99);
    #1 check_eq("latch_busy_wait", 32'(bus.busy), 32'd1);
    cyc();
    #1 check_eq("latch_busy_done", 32'(bus.busy), 32'd0);
    do_acc("r10", 1'b0, 1'b1, 8'd10, 8'h00, rd_v, rv_v, er_v);
    check_eq("r10_rdata", 32'(rd_v), 32'h42);
    do_acc("r11", 1'b0, 1'b1, 8'd11, 8'h00, rd_v, rv_v, er_v);
    check_eq("r11_rdata", 32'(rd_v), 32'h00);

    // Write held across DONE, then a read of the same word in the next IDLE cycle.
    do_acc("w2", 1'b1, 1'b0, 8'd2, 8'h77, rd_v, rv_v, er_v);
    check_eq("w2_rvalid", 32'(rv_v), 32'd0);
    do_acc("r2", 1'b0, 1'b1, 8'd2, 8'h00, rd_v, rv_v, er_v);
    check_eq("r2_rdata", 32'(rd_v), 32'h77);
    check_eq("r2_rvalid", 32'(rv_v), 32'd1);

    // Reset during WAIT aborts the write.
    cyc();
    drive(1'b1, 1'b0, 8'd7, 8'h11);
    #1 check_eq("abort_busy_req", 32'(bus.busy), 32'd1);
    cyc();
    reset = 1'b1;
    #1 check_eq("abort_busy_wait", 32'(bus.busy), 32'd1);
    cyc();
    reset = 1'b0;
    drive(1'b0, 1'b0, 8'd0, 8'h00);
    #1;
    check_eq("abort_busy_after", 32'(bus.busy), 32'd0);
    check_eq("abort_rvalid_after", 32'(bus.rvalid), 32'd0);
    do_acc("r7", 1'b0, 1'b1, 8'd7, 8'h00, rd_v, rv_v, er_v);
    check_eq("r7_rdata", 32'(rd_v), 32'h00);
    check_eq("r7_rvalid", 32'(rv_v), 32'd1);
`else
    cyc();
    drive(1'b1, 1'b0, 8'd9, 8'h5A);
    #1;
    check_eq("w9_busy", 32'(bus.busy), 32'd0);
    check_eq("w9_rvalid", 32'(bus.rvalid), 32'd0);
    check_eq("w9_rdata", 32'(bus.rdata), 32'h00);
    check_eq("w9_err", 32'(bus.err), 32'd0);
    cyc();
    drive(1'b0, 1'b1, 8'd9, 8'h00);
    #1;
    check_eq("r9_rdata", 32'(bus.rdata), 32'h5A);
    check_eq("r9_rvalid", 32'(bus.rvalid), 32'd1);
    check_eq("r9_busy", 32'(bus.busy), 32'd0);

    cyc();
    drive(1'b1, 1'b1, 8'd3, 8'h3C);
    #1;
    check_eq("both3_rvalid", 32'(bus.rvalid), 32'd0);
    check_eq("both3_rdata_old", 32'(bus.rdata), 32'h00);
    cyc();
    drive(1'b0, 1'b1, 8'd3, 8'h00);
    #1 check_eq("r3_rdata", 32'(bus.rdata), 32'h3C);

    cyc();
    drive(1'b1, 1'b0, 8'd40, 8'hFF);
    #1;
    check_eq("w40_err", 32'(bus.err), 32'd1);
    check_eq("w40_busy", 32'(bus.busy), 32'd0);
    cyc();
    drive(1'b0, 1'b1, 8'd40, 8'h00);
    #1;
    check_eq("r40_rdata", 32'(bus.rdata), 32'h00);
    check_eq("r40_rvalid", 32'(bus.rvalid), 32'd1);
    check_eq("r40_err", 32'(bus.err), 32'd1);
    cyc();
    drive(1'b0, 1'b1, 8'd8, 8'h00);
    #1;
    check_eq("r8_alias_rdata", 32'(bus.rdata), 32'h00);
    check_eq("r8_err", 32'(bus.err), 32'd0);

    cyc();
    drive(1'b0, 1'b0, 8'd9, 8'h00);
    #1;
    check_eq("idle_rdata", 32'(bus.rdata), 32'h00);
    check_eq("idle_rvalid", 32'(bus.rvalid), 32'd0);

    // Reset concurrent with a write: reset wins.
    cyc();
    reset = 1'b1;
    drive(1'b1, 1'b0, 8'd7, 8'h11);
    cyc();
    reset = 1'b0;
    drive(1'b0, 1'b1, 8'd7, 8'h00);
    #1 check_eq("r7_after_rst", 32'(bus.rdata), 32'h00);
    drive(1'b0, 1'b1, 8'd9, 8'h00);
    #1 check_eq("r9_after_rst", 32'(bus.rdata), 32'h00);
`endif

    cyc();
    drive(1'b0, 1'b0, 8'd0, 8'h00);
    cyc();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
